delay_tap_calibrator: RTL and testbench
=======================================

Name: delay_tap_calibrator

Overview:
- Controller that selects the tap of an external tapped chain of unit buffers (about 1 ns per stage) so that the delayed signal aligns with a reference edge.
- Sweeps tap_sel upward from 0, samples the phase-detector bit after each step and locks on the first tap where the sample reads 1.
- Sits beside the buffer chain and its tap mux; downstream logic consumes tap_sel and locked.

Parameters:
- NUM_TAPS, 16, number of selectable taps (legal range 2..256).
- TAP_W, 4, width of tap_sel; must satisfy 2^TAP_W >= NUM_TAPS.
- SETTLE_CYCLES, 4, clk cycles waited after each tap change before sampling; must be >= 3 to cover the 2-flop synchronizer.
- RETRY_LIMIT, 2, full sweeps attempted before declaring failure (>= 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous assertion, active-high.
- start  in  1  one-cycle pulse that begins calibration; ignored while busy=1.
- phase_in  in  1  raw phase-detector bit from the delay chain; asynchronous to clk.
- tap_sel  out  TAP_W  tap select driven to the chain mux.
- busy  out  1  high from the cycle after start until done.
- locked  out  1  high while a valid tap is held.
- fail  out  1  sticky failure flag; cleared by the next start.
- done  out  1  one-cycle pulse when calibration ends, in either LOCKED or FAIL.

Behaviour:
- Reset (async, rst=1): state=IDLE, tap_sel=0, busy=0, locked=0, fail=0, done=0, settle counter=0, retry counter=0, synchronizer flops=0.
- phase_in passes through a 2-flop synchronizer; only the synchronized value (ph_s) is used.
- States: IDLE, SETTLE, SAMPLE, LOCKED, FAIL.
- IDLE/LOCKED/FAIL + start=1:
  - next state SETTLE, tap_sel=0, settle counter=0, retry counter=0.
  - locked=0, fail=0, busy=1.
- SETTLE: counter increments each cycle; after SETTLE_CYCLES cycles in SETTLE, go to SAMPLE.
- SAMPLE (single cycle), evaluated in priority order:
  - ph_s=1: go to LOCKED, hold tap_sel, locked=1, busy=0, done=1 for one cycle.
  - ph_s=0 and tap_sel<NUM_TAPS-1: tap_sel+1, go to SETTLE.
  - ph_s=0 and tap_sel==NUM_TAPS-1 and retry+1<RETRY_LIMIT: retry+1, tap_sel=0, go to SETTLE.
  - Otherwise: go to FAIL, fail=1, busy=0, done=1, tap_sel=0.
- Tap 0 reading 1 locks at tap 0. This is a legal result, not an error.
- tap_sel never exceeds NUM_TAPS-1, and never changes outside SAMPLE, start or reset.
- Latency: the first sample lands SETTLE_CYCLES+1 cycles after start. A lock at tap k in sweep r (0-based) asserts done at start + 1 + (r*NUM_TAPS + k + 1)*(SETTLE_CYCLES+1) cycles.
- start while busy=1 is ignored with no side effects.
- start in the same cycle that done fires is ignored.
- rst mid-sweep returns immediately to reset values; no done pulse.
- locked and fail are never both 1.
- done is high only in the cycle after SAMPLE resolves.

Optional Feature:
- Macro DELAY_TAP_TRACK_EN.
- Defined: in LOCKED, resample ph_s every 64 cycles.
  - ph_s=0: tap_sel+1, saturating at NUM_TAPS-1.
  - ph_s=1 twice consecutively: tap_sel-1, saturating at 0.
  - locked stays 1 and no done pulse is generated.
- Undefined: LOCKED holds tap_sel constant until start or rst; tracking logic is absent.

Test Plan:
- rst=1 at t=0, released after 3 cycles -> tap_sel=0, busy=locked=fail=done=0; start held at 0 -> outputs unchanged for 100 cycles.
- phase_in driven 1 when tap_sel>=5, defaults, pulse start -> busy=1; lock at tap 5; done pulses exactly 1+6*5=31 cycles after start; locked=1, tap_sel=5.
- phase_in stuck 0, RETRY_LIMIT=2 -> two full sweeps of 0..15, then fail=1, done one pulse at 1+32*5=161 cycles, tap_sel=0, locked=0.
- phase_in stuck 1 -> lock at tap 0 with done 6 cycles after start; a second start pulse while busy is ignored.
- rst asserted while tap_sel=7 mid-sweep -> all outputs zero in the same cycle (async); no done; a new start re-sweeps from 0.
- With DELAY_TAP_TRACK_EN: after lock at 5, drop phase_in to 0 -> tap_sel=6 within 64+3 cycles; locked stays 1.

Source files
------------

// File: rtl/delay_tap_calibrator.sv
// delay_tap_calibrator
//   Chooses the tap of an external chain of unit buffers so that the delayed
//   signal lines up with a reference edge. tap_sel sweeps upward from 0. After
//   each step the block waits for the chain and the synchronizer to settle,
//   then samples the phase detector. It locks on the first tap that reads 1.
//   If every sweep finds no such tap, it reports failure.
//
// Optional build macro: DELAY_TAP_TRACK_EN
//   When defined, the LOCKED state resamples the phase every 64 cycles and
//   nudges tap_sel by one step to follow drift. When undefined, tap_sel holds
//   while LOCKED.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-high reset
//   start     in   one-cycle pulse that begins calibration
//   phase_in  in   raw phase-detector bit, asynchronous to clk
//   tap_sel   out  tap select to the chain mux
//   busy      out  calibration in progress
//   locked    out  a valid tap is being held
//   fail      out  sticky failure flag, cleared by the next start
//   done      out  one-cycle pulse when calibration ends
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start after reset
// SETTLE  | waiting SETTLE_CYCLES for the chain and synchronizer
// SAMPLE  | single cycle: evaluate ph_s and advance or finish
// LOCKED  | holding the tap that first read 1
// FAIL    | every sweep exhausted, tap_sel parked at 0

module delay_tap_calibrator #(
  parameter int NUM_TAPS      = 16,
  parameter int TAP_W         = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int RETRY_LIMIT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             phase_in,
  output logic [TAP_W-1:0] tap_sel,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic             done
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RET_W = $clog2(RETRY_LIMIT + 1);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_LIM  = RET_W'(RETRY_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_SAMPLE = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t             state_q, state_nxt;
  logic [TAP_W-1:0]   tap_q, tap_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [RET_W-1:0]   retry_q, retry_nxt;
  logic               done_q, done_nxt;
  logic               ph_m, ph_s;
  logic               go;

`ifdef DELAY_TAP_TRACK_EN
  logic [5:0]         trk_q, trk_nxt;
  logic               hi_q, hi_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_m <= 1'b0;
      ph_s <= 1'b0;
    end else begin
      ph_m <= phase_in;
      ph_s <= ph_m;
    end
  end

  // A start that coincides with the done pulse is dropped. This gives the
  // consumer one clean cycle to see the result before a restart can clear it.
  assign go = start && !done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
`ifdef DELAY_TAP_TRACK_EN
      trk_q   <= '0;
      hi_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      tap_q   <= tap_nxt;
      cnt_q   <= cnt_nxt;
      retry_q <= retry_nxt;
      done_q  <= done_nxt;
`ifdef DELAY_TAP_TRACK_EN
      trk_q   <= trk_nxt;
      hi_q    <= hi_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    tap_nxt   = tap_q;
    cnt_nxt   = cnt_q;
    retry_nxt = retry_q;
    done_nxt  = 1'b0;
`ifdef DELAY_TAP_TRACK_EN
    trk_nxt   = trk_q;
    hi_nxt    = hi_q;
`endif
    case (state_q)
      S_IDLE, S_FAIL: begin
        if (go) begin
          state_nxt = S_SETTLE;
          tap_nxt   = '0;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      S_LOCKED: begin
        if (go) begin
          state_nxt = S_SETTLE;
          tap_nxt   = '0;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
`ifdef DELAY_TAP_TRACK_EN
        // Drift tracking. A single 0 moves the tap later. Two 1s in a row are
        // required before moving earlier, so the tap does not dither around
        // the edge.
        else if (trk_q == 6'd0) begin
          trk_nxt = 6'd63;
          if (!ph_s) begin
            hi_nxt = 1'b0;
            if (tap_q < TAP_LAST) tap_nxt = tap_q + TAP_W'(1);
          end else if (hi_q) begin
            hi_nxt = 1'b0;
            if (tap_q != '0) tap_nxt = tap_q - TAP_W'(1);
          end else begin
            hi_nxt = 1'b1;
          end
        end else begin
          trk_nxt = trk_q - 6'd1;
        end
`endif
      end
      S_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (ph_s) begin
          state_nxt = S_LOCKED;
          done_nxt  = 1'b1;
`ifdef DELAY_TAP_TRACK_EN
          trk_nxt   = 6'd63;
          hi_nxt    = 1'b0;
`endif
        end else if (tap_q < TAP_LAST) begin
          tap_nxt   = tap_q + TAP_W'(1);
          state_nxt = S_SETTLE;
        end else if ((retry_q + RET_W'(1)) < RET_LIM) begin
          retry_nxt = retry_q + RET_W'(1);
          tap_nxt   = '0;
          state_nxt = S_SETTLE;
        end else begin
          state_nxt = S_FAIL;
          done_nxt  = 1'b1;
          tap_nxt   = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tap_sel = tap_q;
    busy    = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    locked  = (state_q == S_LOCKED);
    fail    = (state_q == S_FAIL);
    done    = done_q;
  end

endmodule

// File: tb/tb_delay_tap_calibrator.sv
module tb_delay_tap_calibrator;

  localparam int NT = 16;
  localparam int SC = 4;
  localparam int RL = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       phase_in;
  logic [3:0] tap_sel;
  logic       busy, locked, fail, done;

  int thr;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The environment: the delayed edge lines up with the reference from tap thr onward.
  assign phase_in = (int'(tap_sel) >= thr);

  delay_tap_calibrator #(
    .NUM_TAPS(NT), .TAP_W(4), .SETTLE_CYCLES(SC), .RETRY_LIMIT(RL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .phase_in(phase_in),
    .tap_sel(tap_sel), .busy(busy), .locked(locked), .fail(fail), .done(done)
  );

  typedef struct {
    int thr;
    int e_tap;
    bit e_lock;
    int e_cyc;
  } vec_t;

  vec_t vt[4];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: walk the sweeps as the behaviour describes. Each tap costs
  // a settle window plus one sample cycle. Lock on the first tap whose phase
  // reads 1. Otherwise fail after RL sweeps.
  function automatic void model(input int th, output int e_tap, output bit e_lock,
                                output int e_cyc);
    e_cyc = 1;
    for (int r = 0; r < RL; r++) begin
      for (int k = 0; k < NT; k++) begin
        e_cyc += SC + 1;
        if (k >= th) begin
          e_tap  = k;
          e_lock = 1'b1;
          return;
        end
      end
    end
    e_tap  = 0;
    e_lock = 1'b0;
  endfunction

  task automatic run_cal(input string nm, input int th, input int e_tap, input bit e_lock,
                         input int e_cyc, input int dup_at, input bit start_on_done);
    int cyc;
    thr = th;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 1;
    chk({nm, " busy"}, int'(busy), 1);
    while (!done && cyc < 400) begin
      if (cyc == dup_at) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      cyc++;
    end
    chk({nm, " done_cycle"}, cyc, e_cyc);
    chk({nm, " tap_sel"}, int'(tap_sel), e_tap);
    chk({nm, " locked"}, int'(locked), int'(e_lock));
    chk({nm, " fail"}, int'(fail), int'(!e_lock));
    chk({nm, " busy_end"}, int'(busy), 0);
    start = start_on_done;
    @(posedge clk); #1 start = 1'b0;
    chk({nm, " done_width"}, int'(done), 0);
    chk({nm, " hold_locked"}, int'(locked), int'(e_lock));
    chk({nm, " hold_busy"}, int'(busy), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e_tap, e_cyc, nd, wc;
    bit e_lock;

    vt[0] = '{thr: 5,  e_tap: 5,  e_lock: 1'b1, e_cyc: 31};
    vt[1] = '{thr: 0,  e_tap: 0,  e_lock: 1'b1, e_cyc: 6};
    vt[2] = '{thr: 16, e_tap: 0,  e_lock: 1'b0, e_cyc: 161};
    vt[3] = '{thr: 15, e_tap: 15, e_lock: 1'b1, e_cyc: 81};

    rst = 1'b1; start = 1'b0; thr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset outputs", int'({tap_sel, busy, locked, fail, done}), 0);
    wc = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if ({tap_sel, busy, locked, fail, done} != 8'd0) wc++;
    end
    chk("idle_100 changes", wc, 0);

    for (int i = 0; i < 4; i++)
      run_cal($sformatf("vec%0d", i), vt[i].thr, vt[i].e_tap, vt[i].e_lock, vt[i].e_cyc, 0, 1'b0);

    // A second start while busy must not restart the sweep.
    run_cal("dup_start", 0, 0, 1'b1, 6, 3, 1'b0);
    // A start in the done cycle is ignored, so the lock must still be held.
    run_cal("start_on_done", 7, 7, 1'b1, 41, 0, 1'b1);
    run_cal("start_on_done_fail", 20, 0, 1'b0, 161, 0, 1'b1);

    // Reset in the middle of a sweep.
    thr = 99;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wc = 0;
    while (tap_sel != 4'd7 && wc < 200) begin
      @(posedge clk); #1;
      wc++;
    end
    chk("reach tap7", int'(tap_sel), 7);
    #2 rst = 1'b1;
    #1 chk("async rst outputs", int'({tap_sel, busy, locked, fail, done}), 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    chk("no done after rst", nd, 0);
    run_cal("resweep", 5, 5, 1'b1, 31, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      int th;
      th = int'($urandom_range(0, 19));
      model(th, e_tap, e_lock, e_cyc);
      run_cal($sformatf("rand%0d_thr%0d", i, th), th, e_tap, e_lock, e_cyc,
              int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
